meteor_spawner: RTL

Consumer side of the pseudo-random spawn source. Every `SPAWN_INTERVAL` frames it samples the random position, speed and sign values, picks the lowest-numbered free meteor slot, and shapes the values into a legal spawn record. It then offers the record to the meteor array over a valid/ready handshake. It sits between the random counter and the per-meteor motion blocks in the game top level.

---
 rtl/meteor_pkg.sv | 26 ++
 rtl/meteor_spawner_if.sv | 21 ++
 rtl/lowest_free_slot.sv | 22 ++
 rtl/meteor_spawner.sv | 104 ++++++++++
 4 files changed

// File: rtl/meteor_pkg.sv
// Types and defaults shared by the meteor spawner and the per-meteor motion blocks.
package meteor_pkg;

    localparam int unsigned DEF_SCREEN_W  = 640;
    localparam int unsigned DEF_MIN_SPEED = 1;
    localparam int unsigned MAX_SLOT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        OFFER  = 2'd2
    } spawner_state_t;

    typedef struct packed {
        logic [MAX_SLOT_W-1:0] slot;
        logic [9:0]            x;
        logic [3:0]            vx;
        logic [2:0]            vy;
    } spawn_rec_t;

    // A zero magnitude would leave a meteor parked, so it is bumped up.
    function automatic logic [2:0] clamp_speed(logic [2:0] mag, logic [2:0] min_speed);
        return (mag == 3'd0) ? min_speed : mag;
    endfunction

endpackage

// File: rtl/meteor_spawner_if.sv
// Spawn record handshake between the spawner (master) and the meteor array (slave).
interface meteor_spawner_if #(
    parameter int unsigned NUM_METEORS = 8
);
    logic                           spawn_valid;
    logic                           spawn_ready;
    logic [$clog2(NUM_METEORS)-1:0] spawn_slot;
    logic [9:0]                     spawn_x;
    logic [3:0]                     spawn_vx;
    logic [2:0]                     spawn_vy;

    modport master (
        output spawn_valid, spawn_slot, spawn_x, spawn_vx, spawn_vy,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid, spawn_slot, spawn_x, spawn_vx, spawn_vy,
        output spawn_ready
    );
endinterface

// File: rtl/lowest_free_slot.sv
// Combinational priority encoder: index of the lowest free meteor slot.
module lowest_free_slot #(
    parameter int unsigned NUM_METEORS = 8
) (
    input  logic [NUM_METEORS-1:0]         slot_free,
    output logic                           any_free,
    output logic [$clog2(NUM_METEORS)-1:0] slot_idx
);
    localparam int unsigned SLOT_W = $clog2(NUM_METEORS);

    assign any_free = |slot_free;

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        slot_idx = '0;
        for (int i = NUM_METEORS - 1; i >= 0; i--) begin
            if (slot_free[i]) begin
                slot_idx = SLOT_W'(i);
            end
        end
    end
endmodule

// File: rtl/meteor_spawner.sv
// Periodic meteor spawner: counts frames, shapes random values into a spawn record
// and offers it to the meteor array over a valid/ready handshake.
module meteor_spawner
    import meteor_pkg::*;
#(
    parameter int unsigned NUM_METEORS    = 8,
    parameter int unsigned SPAWN_INTERVAL = 60,
    parameter int unsigned SCREEN_W       = DEF_SCREEN_W,
    parameter int unsigned MIN_SPEED      = DEF_MIN_SPEED
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_tick,
    input  logic                   spawn_enable,
    input  logic [9:0]             rand_pos,
    input  logic [2:0]             rand_x_speed,
    input  logic [2:0]             rand_y_speed,
    input  logic                   rand_sign,
    input  logic [NUM_METEORS-1:0] slot_free,
    meteor_spawner_if.master       spawn,
    output logic                   spawn_dropped,
    output logic [15:0]            spawn_count
);
    localparam int unsigned SLOT_W = $clog2(NUM_METEORS);
    localparam int unsigned CNT_W  = $clog2(SPAWN_INTERVAL + 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(SPAWN_INTERVAL - 1);

    spawner_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    spawn_rec_t       rec_q, shaped;
    logic             dropped_q;
    logic [15:0]      count_q;
    logic             any_free;
    logic [SLOT_W-1:0] free_idx;
    logic [2:0]       mag_x, mag_y;

    lowest_free_slot #(
        .NUM_METEORS(NUM_METEORS)
    ) u_lowest_free_slot (
        .slot_free(slot_free),
        .any_free (any_free),
        .slot_idx (free_idx)
    );

    always_comb begin
        mag_x       = clamp_speed(rand_x_speed, 3'(MIN_SPEED));
        mag_y       = clamp_speed(rand_y_speed, 3'(MIN_SPEED));
        shaped.slot = MAX_SLOT_W'(free_idx);
        shaped.x    = ({1'b0, rand_pos} < 11'(SCREEN_W)) ? rand_pos : rand_pos - 10'(SCREEN_W);
        shaped.vx   = rand_sign ? 4'd0 - {1'b0, mag_x} : {1'b0, mag_x};
        shaped.vy   = mag_y;
    end

    // The frame counter only moves in IDLE; ticks seen while sampling or offering are lost.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!spawn_enable) begin
                    cnt_d = '0;
                end else if (frame_tick) begin
                    if (cnt_q == LAST_FRAME) begin
                        cnt_d   = '0;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SAMPLE:  state_d = any_free ? OFFER : IDLE;
            OFFER:   if (spawn.spawn_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rec_q     <= '0;
            dropped_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dropped_q <= (state_q == SAMPLE) && !any_free;
            if ((state_q == SAMPLE) && any_free) begin
                rec_q <= shaped;
            end
            if ((state_q == OFFER) && spawn.spawn_ready) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign spawn.spawn_valid = (state_q == OFFER);
    assign spawn.spawn_slot  = SLOT_W'(rec_q.slot);
    assign spawn.spawn_x     = rec_q.x;
    assign spawn.spawn_vx    = rec_q.vx;
    assign spawn.spawn_vy    = rec_q.vy;
    assign spawn_dropped     = dropped_q;
    assign spawn_count       = count_q;
endmodule
